// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 key event controller
package ps2_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_EXT     = 2'd1;
    localparam state_t ST_BRK     = 2'd2;
    localparam state_t ST_EXT_BRK = 2'd3;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // Receiver chatter (BAT result, ACK, echo, resend, errors, pause lead-in)
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'hE1) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous event FIFO; a same-cycle pop frees a slot for push
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             push_ok,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// rtl/ps2_key_event_ctrl.sv - Set-2 prefix sequencer, held-key bitmap and event queue
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic [4:0] keys_held,
    output logic       overflow,
    input  logic       overflow_clr
);
    logic        scan_d;
    logic        accept;
    state_t      state;
    state_t      state_n;
    logic [31:0] tmo_cnt;
    logic        emit_n;
    ps2_event_t  evt_n;
    logic        emit_q;
    ps2_event_t  evt_q;
    ps2_event_t  head;
    logic        push_ok;
    logic        fifo_full;
    logic        fifo_empty;
    logic        is_prefix;

    assign accept    = scan_valid && !scan_d;
    assign is_prefix = (scan_code == PS2_EXT) || (scan_code == PS2_BRK);

    always_comb begin
        state_n = state;
        emit_n  = 1'b0;
        evt_n   = '{ext: 1'b0, brk: 1'b0, code: scan_code};
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == PS2_EXT)      state_n = ST_EXT;
                    else if (scan_code == PS2_BRK) state_n = ST_BRK;
                    else if (!is_discard(scan_code)) emit_n = 1'b1;
                end
                ST_EXT: begin
                    if (scan_code == PS2_BRK) begin
                        state_n = ST_EXT_BRK;
                    end else if (scan_code != PS2_EXT) begin
                        state_n   = ST_IDLE;
                        emit_n    = 1'b1;
                        evt_n.ext = 1'b1;
                    end
                end
                ST_BRK: begin
                    // A second prefix after F0 is a protocol error: drop the sequence
                    state_n   = ST_IDLE;
                    emit_n    = !is_prefix;
                    evt_n.brk = 1'b1;
                end
                default: begin
                    state_n   = ST_IDLE;
                    emit_n    = !is_prefix;
                    evt_n.brk = 1'b1;
                    evt_n.ext = 1'b1;
                end
            endcase
        end else if (state != ST_IDLE && tmo_cnt == '0) begin
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan_d  <= 1'b0;
            state   <= ST_IDLE;
            tmo_cnt <= '0;
            emit_q  <= 1'b0;
            evt_q   <= '0;
        end else begin
            scan_d <= scan_valid;
            state  <= state_n;
            emit_q <= emit_n;
            evt_q  <= evt_n;
            if (accept) begin
                tmo_cnt <= 32'(TIMEOUT_CYCLES);
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 32'd1;
            end
        end
    end

    // Bitmap tracks every emitted event, even ones the FIFO had to drop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            keys_held <= '0;
        end else if (emit_q) begin
            if (evt_q.ext) begin
                case (evt_q.code)
                    KEY_UP:    keys_held[0] <= !evt_q.brk;
                    KEY_DOWN:  keys_held[1] <= !evt_q.brk;
                    KEY_LEFT:  keys_held[2] <= !evt_q.brk;
                    KEY_RIGHT: keys_held[3] <= !evt_q.brk;
                    default:   keys_held    <= keys_held;
                endcase
            end else if (evt_q.code == KEY_SPACE) begin
                keys_held[4] <= !evt_q.brk;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (emit_q && !push_ok) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    ps2_event_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (emit_q),
        .push_data (evt_q),
        .pop       (evt_valid && evt_ready),
        .head      (head),
        .push_ok   (push_ok),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = fifo_empty ? 8'h00 : head.code;
    assign evt_break = fifo_empty ? 1'b0  : head.brk;
    assign evt_ext   = fifo_empty ? 1'b0  : head.ext;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb/tb_ps2_key_event_ctrl.sv - self-checking bench for ps2_key_event_ctrl
module tb_ps2_key_event_ctrl;
    localparam int DEPTH = 4;
    localparam int TMO   = 50;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic [4:0] keys_held;
    logic       overflow;
    logic       overflow_clr;

    int nvec = 0;
    int nerr = 0;

    logic [9:0] q[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [4:0] m_keys = '0;
    logic       m_ovf = 1'b0;

    logic [7:0] pool [13] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29,
                              8'h1C, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'hE1};

    ps2_key_event_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .scan_valid   (scan_valid),
        .scan_code    (scan_code),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_break    (evt_break),
        .evt_ext      (evt_ext),
        .keys_held    (keys_held),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pending-prefix flags rather than a state machine: E0 and F0 each mark what was seen
    task automatic model_byte(input logic [7:0] b);
        logic discard;
        discard = (b == 8'hE1) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
                  (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
        if (b == 8'hE0 || b == 8'hF0) begin
            if (m_brk) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else begin
                m_brk = 1'b1;
            end
        end else if (!m_ext && !m_brk && discard) begin
            m_ext = 1'b0;
        end else begin
            if (q.size() < DEPTH) q.push_back({m_ext, m_brk, b});
            else m_ovf = 1'b1;
            if (m_ext && b == 8'h75) m_keys[0] = !m_brk;
            if (m_ext && b == 8'h72) m_keys[1] = !m_brk;
            if (m_ext && b == 8'h6B) m_keys[2] = !m_brk;
            if (m_ext && b == 8'h74) m_keys[3] = !m_brk;
            if (!m_ext && b == 8'h29) m_keys[4] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        scan_code  = b;
        scan_valid = 1'b1;
        repeat (hold) @(negedge clk);
        scan_valid = 1'b0;
        repeat (3) @(negedge clk);
        model_byte(b);
    endtask

    task automatic drain();
        logic [10:0] exp;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (!evt_valid && q.size() == 0) break;
            exp = (q.size() != 0) ? {1'b1, q[0]} : 11'h0;
            check("evt_head", {21'h0, evt_valid, evt_ext, evt_break, evt_code}, {21'h0, exp});
            if (q.size() != 0) void'(q.pop_front());
            if (evt_valid) begin
                evt_ready = 1'b1;
                @(negedge clk);
                evt_ready = 1'b0;
            end
        end
        check("fifo_empty", {31'h0, evt_valid}, 32'h0);
        check("keys_held", {27'h0, keys_held}, {27'h0, m_keys});
    endtask

    initial begin
        logic [7:0] b;
        reset_n = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
        evt_ready = 1'b0; overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_outs", {16'h0, evt_valid, evt_ext, evt_break, evt_code, keys_held},
              32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);

        // Basic make/break, plain and extended
        send_byte(8'h1C, 1); drain();
        send_byte(8'hE0, 1); send_byte(8'h75, 2); drain();
        check("up_held", {31'h0, keys_held[0]}, 32'h1);
        send_byte(8'hF0, 1); send_byte(8'h1C, 1); drain();
        send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h75, 1); drain();
        check("up_released", {31'h0, keys_held[0]}, 32'h0);

        // Overflow: five makes into a four-deep queue
        send_byte(8'h1C, 1); send_byte(8'h1B, 1); send_byte(8'h23, 1);
        send_byte(8'h2B, 1); send_byte(8'h29, 1);
        check("ovf_set", {31'h0, overflow}, {31'h0, m_ovf});
        check("ovf_keys", {27'h0, keys_held}, {27'h0, m_keys});
        drain();
        @(negedge clk); overflow_clr = 1'b1;
        @(negedge clk); overflow_clr = 1'b0; m_ovf = 1'b0;
        check("ovf_clr", {31'h0, overflow}, 32'h0);
        send_byte(8'hF0, 1); send_byte(8'h29, 1); drain();

        // Abandoned E0 prefix times out
        send_byte(8'hE0, 1);
        repeat (TMO) @(negedge clk);
        m_ext = 1'b0; m_brk = 1'b0;
        send_byte(8'h29, 1); drain();
        check("tmo_space", {31'h0, keys_held[4]}, 32'h1);
        send_byte(8'hF0, 1); send_byte(8'h29, 1); drain();

        // Long strobe still yields one byte
        send_byte(8'h29, 10); drain();
        send_byte(8'hF0, 1); send_byte(8'h29, 1); drain();

        // Chatter and double break are swallowed
        send_byte(8'hAA, 1); send_byte(8'hFA, 1);
        send_byte(8'hF0, 1); send_byte(8'hF0, 1);
        check("no_evt", {31'h0, evt_valid}, 32'h0);
        send_byte(8'h6B, 1); drain();

        // Full queue: pop and push land on the same edge
        send_byte(8'h1C, 1); send_byte(8'h1B, 1); send_byte(8'h23, 1); send_byte(8'h2B, 1);
        @(negedge clk); scan_code = 8'h34; scan_valid = 1'b1;
        @(negedge clk);
        check("full_head", {22'h0, evt_valid, evt_ext, evt_break, evt_code}, {22'h0, 1'b1, q[0]});
        evt_ready = 1'b1; scan_valid = 1'b0;
        @(negedge clk); evt_ready = 1'b0;
        void'(q.pop_front());
        model_byte(8'h34);
        check("full_no_ovf", {31'h0, overflow}, 32'h0);
        drain();

        // Reset mid-sequence with queued event and a held key
        send_byte(8'h29, 1); send_byte(8'hE0, 1); send_byte(8'hF0, 1);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        q.delete(); m_ext = 1'b0; m_brk = 1'b0; m_keys = '0; m_ovf = 1'b0;
        check("rst2_outs", {16'h0, evt_valid, evt_ext, evt_break, evt_code, keys_held}, 32'h0);
        send_byte(8'h75, 1); drain();

        // Random byte streams against the reference model
        for (int i = 0; i < 200; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 12)];
            send_byte(b, $urandom_range(1, 4));
            drain();
        end
        check("final_ovf", {31'h0, overflow}, {31'h0, m_ovf});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Sequencing controller downstream of the PS/2 serial-to-scancode receiver. Consumes raw scancode bytes, tracks Set-2 prefixes (E0 extended, F0 break) with a state machine, and emits complete key events into a small FIFO with a valid/ready handshake. Maintains a live held-key bitmap for the five game keys, so game logic can poll key state or consume edge events.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 2_000_000, idle cycles after a prefix before abandoning the sequence
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- scan_valid  in  1  byte-available strobe from receiver; level, may stay high several cycles
- scan_code  in  8  received byte; stable while scan_valid high
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready
- evt_code  out  8  head event key code (prefixes stripped)
- evt_break  out  1  head event is a release
- evt_ext  out  1  head event carried the E0 prefix
- keys_held  out  5  {space, right, left, down, up} currently pressed
- overflow  out  1  sticky: an event was dropped on a full FIFO
- overflow_clr  in  1  clears overflow

## Operation
- Byte acceptance: one byte is consumed per rising edge of scan_valid (registered previous value). Holding scan_valid high consumes nothing further.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0→EXT; F0→BRK; E1, AA, FA, EE, FE, 00, FF → discarded, stay IDLE; other → emit make {ext=0}.
  - EXT: F0→EXT_BRK; E0 → stay EXT; other → emit make {ext=1}, →IDLE.
  - BRK: any non-prefix → emit break {ext=0}, →IDLE; E0/F0 → protocol error, →IDLE, nothing emitted.
  - EXT_BRK: any non-prefix → emit break {ext=1}, →IDLE; E0/F0 → error, →IDLE.
- Timeout: 32-bit down-counter loaded with TIMEOUT_CYCLES on each accepted byte; in any state ≠ IDLE, reaching zero → IDLE, no event.
- keys_held mapping: up = E0 75, down = E0 72, left = E0 6B, right = E0 74, space = 29 (non-ext). A make sets the bit, a break clears it. Updated on every emitted event, regardless of FIFO state.
- FIFO: push {ext, break, code} on emit. Push is accepted if count < FIFO_DEPTH or a pop occurs in the same cycle. Otherwise the event is dropped and overflow is set. Head outputs are valid only while evt_valid=1.
- overflow: set wins over overflow_clr in the same cycle.
- Reset values: FSM=IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_break=0, evt_ext=0, keys_held=0, overflow=0, timeout counter=0, edge register=0.

## Timing
- scan_valid first high at edge N (low at N−1) → FSM transition and emit at edge N. evt_valid=1 and keys_held updated visible after edge N+1 (1-cycle latency to empty FIFO head).
- Pop at edge M → next entry (or evt_valid=0) visible after edge M.
- Simultaneous push+pop on empty FIFO: the event passes through; evt_valid rises next cycle.
- Reset asserted mid-sequence or with a full FIFO: everything returns to reset values at that edge, and the pending prefix is lost.
- Back-to-back bytes are limited by the receiver (≥ hundreds of cycles apart); no input buffering is required.

## Structure
- Package ps2_pkg: FSM state enum; constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, discard list, five game-key codes; packed event type {ext, brk, code[7:0]}.
- Sub-module ps2_event_fifo: parameterised synchronous FIFO (width 10, FIFO_DEPTH) with push/pop/full/empty and the pop-frees-slot push rule. FSM, timeout, and bitmap stay in the top.

## Test plan
- Bytes 1C; E0 75; F0 1C; E0 F0 75 → events (1C,brk0,ext0), (75,0,1), (1C,1,0), (75,1,1). keys_held.up goes 1 then 0.
- evt_ready=0, send 5 makes (depth 4) → 4 queued, 5th dropped, overflow=1. keys_held is still updated. overflow_clr → 0.
- Send E0, then wait TIMEOUT_CYCLES+1 with no byte, then 29 → single event (29,0,0), not extended; keys_held.space=1.
- Hold scan_valid high 10 cycles with byte 29 → exactly one event.
- Bytes AA, FA, then F0 F0 → no events, FSM back in IDLE. Next 6B → make (6B,0,0).
- Full FIFO with evt_ready=1 and new emit in the same cycle → push accepted, overflow stays 0. Reset mid E0-F0 → IDLE, FIFO empty, keys_held=0.
